coreport_irq_svc: RTL and testbench

- Hardware interrupt service sequencer for a coreport GPIO peripheral.
- Sits between the port's irq output and its Wishbone slave as a Wishbone master. On irq it reads IFR, clears IFR, and queues the captured flag vector into an event FIFO drained by software or a DMA-style consumer.
- Removes the read-then-clear IFR handling from the CPU.

---
 rtl/coreport_irq_svc.sv | 171 +++++++++++++++++
 tb/tb_coreport_irq_svc.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coreport_irq_svc.sv
// Interrupt service sequencer for a coreport GPIO port. On irq it reads IFR over Wishbone,
// clears IFR, and queues the non-zero flag snapshot into a small event FIFO.
module coreport_irq_svc #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          READ_DLY    = 1,
  parameter int          HOLDOFF     = 2,
  parameter int          ACK_TIMEOUT = 15
) (
  input  logic                          wb_clk,
  input  logic                          wb_rst_n,
  input  logic                          enable,
  input  logic                          irq_i,
  output logic [31:0]                   m_adr_o,
  output logic [WIDTH-1:0]              m_dat_o,
  input  logic [WIDTH-1:0]              m_dat_i,
  output logic                          m_we_o,
  output logic                          m_cyc_o,
  output logic                          m_stb_o,
  output logic [2:0]                    m_cti_o,
  output logic [1:0]                    m_bte_o,
  input  logic                          m_ack_i,
  input  logic                          m_err_i,
  output logic                          evt_valid,
  output logic [WIDTH-1:0]              evt_data,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   evt_level,
  output logic                          evt_overflow,
  output logic                          bus_fault,
  input  logic                          sticky_clr,
  output logic                          busy
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam int          LW        = AW + 1;
  localparam logic [31:0] IFR_ADR   = BASE_ADR + 32'h0000_000C;
  localparam bit          ZERO_DLY  = (READ_DLY == 0);
  localparam logic [7:0]  DLY_LAST  = 8'((READ_DLY > 0) ? READ_DLY - 1 : 0);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLDOFF - 1);
  localparam logic [7:0]  TO_LAST   = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RDLAT, S_WR, S_PUSH, S_HOLD
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_cnt;
  logic [WIDTH-1:0] r_flags;
  logic             r_overflow, r_bus_fault;

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]    r_level;

  logic w_stb, w_fault, w_sample, w_full, w_pop, w_push, w_ovf_set;

  // Shared per-state counter: stall cycles in RD/WR, latency in RDLAT, quiet time in HOLD.
  assign w_stb    = (r_state == S_RD) || (r_state == S_WR);
  assign w_fault  = w_stb && (m_err_i || (!m_ack_i && (r_cnt == TO_LAST)));
  assign w_sample = (r_state == S_RDLAT && r_cnt == DLY_LAST) ||
                    (ZERO_DLY && r_state == S_RD && m_ack_i && !w_fault);

  // State register
  always_ff @(posedge wb_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!wb_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (w_state_nxt != r_state) ? 8'd0 : r_cnt + 8'd1;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (enable && irq_i) w_state_nxt = S_RD;
      S_RD: begin
        if (w_fault)      w_state_nxt = S_IDLE;
        else if (m_ack_i) begin
          if (ZERO_DLY)   w_state_nxt = (m_dat_i != '0) ? S_WR : S_IDLE;
          else            w_state_nxt = S_RDLAT;
        end
      end
      S_RDLAT: if (r_cnt == DLY_LAST) w_state_nxt = (m_dat_i != '0) ? S_WR : S_IDLE;
      S_WR: begin
        if (w_fault)      w_state_nxt = S_IDLE;
        else if (m_ack_i) w_state_nxt = S_PUSH;
      end
      S_PUSH:  w_state_nxt = S_HOLD;
      S_HOLD:  if (r_cnt == HOLD_LAST) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus and status outputs
  always_comb begin
    m_cyc_o = 1'b0;
    m_stb_o = 1'b0;
    m_we_o  = 1'b0;
    m_adr_o = 32'd0;
    busy    = (r_state != S_IDLE);
    if (w_stb) begin
      m_cyc_o = 1'b1;
      m_stb_o = 1'b1;
      m_we_o  = (r_state == S_WR);
      m_adr_o = IFR_ADR;
    end
  end

  assign m_dat_o = '0;
  assign m_cti_o = 3'b000;
  assign m_bte_o = 2'b00;

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n)     r_flags <= '0;
    else if (w_sample) r_flags <= m_dat_i;
  end

  // Event FIFO; a push in a full cycle only succeeds when the consumer pops in that cycle.
  assign w_full    = (r_level == LW'(FIFO_DEPTH));
  assign evt_valid = (r_level != '0);
  assign w_pop     = evt_valid && evt_ready;
  assign w_push    = (r_state == S_PUSH) && (!w_full || w_pop);
  assign w_ovf_set = (r_state == S_PUSH) && w_full && !w_pop;

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // NOTE: storage has no reset; occupancy is tracked by the reset pointers and level alone.
  always_ff @(posedge wb_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_flags;
  end

  assign evt_data  = evt_valid ? r_mem[r_rd_ptr] : '0;
  assign evt_level = r_level;

  // Sticky status: a set in the same cycle as sticky_clr wins.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      r_overflow  <= 1'b0;
      r_bus_fault <= 1'b0;
    end else begin
      if (w_ovf_set)       r_overflow <= 1'b1;
      else if (sticky_clr) r_overflow <= 1'b0;
      if (w_fault)         r_bus_fault <= 1'b1;
      else if (sticky_clr) r_bus_fault <= 1'b0;
    end
  end

  assign evt_overflow = r_overflow;
  assign bus_fault    = r_bus_fault;

endmodule

// File: tb/tb_coreport_irq_svc.sv
// Directed bench: instance a uses default parameters with a zero-wait slave,
// instance b uses READ_DLY=2 with a three-wait-state slave.
module tb_coreport_irq_svc;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance a signals and slave model
  logic        a_en, a_irq, a_we, a_cyc, a_stb, a_ack, a_err;
  logic        a_valid, a_ready, a_ovf, a_fault, a_sclr, a_busy;
  logic [31:0] a_adr;
  logic [7:0]  a_dat_o, a_dat_i, a_data, a_ifr;
  logic [2:0]  a_cti, a_level;
  logic [1:0]  a_bte;
  logic        a_noack, a_err_wr;
  logic        a_rd_d1 = 1'b0;
  int          a_wr_cnt = 0;

  assign a_ack   = a_stb && !a_noack;
  assign a_err   = a_stb && a_we && a_err_wr;
  assign a_dat_i = a_rd_d1 ? a_ifr : 8'hEE;

  always @(posedge clk) begin
    a_rd_d1 <= a_ack && !a_we;
    if (a_ack && a_we) a_wr_cnt <= a_wr_cnt + 1;
  end

  coreport_irq_svc dut_a (
    .wb_clk(clk), .wb_rst_n(rst_n), .enable(a_en), .irq_i(a_irq),
    .m_adr_o(a_adr), .m_dat_o(a_dat_o), .m_dat_i(a_dat_i), .m_we_o(a_we),
    .m_cyc_o(a_cyc), .m_stb_o(a_stb), .m_cti_o(a_cti), .m_bte_o(a_bte),
    .m_ack_i(a_ack), .m_err_i(a_err), .evt_valid(a_valid), .evt_data(a_data),
    .evt_ready(a_ready), .evt_level(a_level), .evt_overflow(a_ovf),
    .bus_fault(a_fault), .sticky_clr(a_sclr), .busy(a_busy)
  );

  // Instance b signals and wait-state slave model
  logic        b_en, b_irq, b_we, b_cyc, b_stb, b_ack;
  logic        b_valid, b_ovf, b_fault, b_busy;
  logic [31:0] b_adr;
  logic [7:0]  b_dat_o, b_dat_i, b_data, b_ifr;
  logic [2:0]  b_cti, b_level;
  logic [1:0]  b_bte;
  logic        b_rd_d1 = 1'b0, b_rd_d2 = 1'b0;
  int          b_wait = 0;
  logic        b_prev_stb = 1'b0, b_we_q = 1'b0;
  logic [31:0] b_adr_q = 32'd0;
  int          b_stb_cycles = 0, b_unstable = 0, b_adr_bad = 0;

  assign b_ack   = b_stb && (b_wait == 3);
  assign b_dat_i = b_rd_d2 ? b_ifr : 8'hEE;

  always @(posedge clk) begin
    b_wait  <= (b_stb && !b_ack) ? b_wait + 1 : 0;
    b_rd_d1 <= b_ack && !b_we;
    b_rd_d2 <= b_rd_d1;
  end

  always @(negedge clk) begin
    b_prev_stb <= b_stb;
    b_adr_q    <= b_adr;
    b_we_q     <= b_we;
    if (b_stb) begin
      b_stb_cycles <= b_stb_cycles + 1;
      if (b_adr !== 32'h0000_000C) b_adr_bad <= b_adr_bad + 1;
      if (b_prev_stb && (b_we !== b_we_q || b_adr !== b_adr_q)) b_unstable <= b_unstable + 1;
    end
  end

  coreport_irq_svc #(.READ_DLY(2)) dut_b (
    .wb_clk(clk), .wb_rst_n(rst_n), .enable(b_en), .irq_i(b_irq),
    .m_adr_o(b_adr), .m_dat_o(b_dat_o), .m_dat_i(b_dat_i), .m_we_o(b_we),
    .m_cyc_o(b_cyc), .m_stb_o(b_stb), .m_cti_o(b_cti), .m_bte_o(b_bte),
    .m_ack_i(b_ack), .m_err_i(1'b0), .evt_valid(b_valid), .evt_data(b_data),
    .evt_ready(1'b0), .evt_level(b_level), .evt_overflow(b_ovf),
    .bus_fault(b_fault), .sticky_clr(1'b0), .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle_a(input string name);
    int n = 0;
    while (a_busy && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy still %b after %0d cycles, required 0", name, a_busy, n);
    end
  endtask

  task automatic run_event_a(input logic [7:0] val, input string name);
    a_ifr = val;
    a_irq = 1'b1;
    tick();
    a_irq = 1'b0;
    wait_idle_a(name);
  endtask

  task automatic pulse_sclr();
    a_sclr = 1'b1;
    tick();
    a_sclr = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (a_busy !== 1'b0 || a_cyc !== 1'b0 || a_stb !== 1'b0 || a_we !== 1'b0 || a_adr !== 32'd0) begin
      errors++;
      $display("FAIL reset_bus: busy=%b cyc=%b stb=%b we=%b adr=%h, required all 0", a_busy, a_cyc, a_stb, a_we, a_adr);
    end
    checks++;
    if (a_valid !== 1'b0 || a_level !== 3'd0 || a_data !== 8'h00 || a_ovf !== 1'b0 || a_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_fifo: valid=%b level=%0d data=%h ovf=%b fault=%b, required all 0", a_valid, a_level, a_data, a_ovf, a_fault);
    end
    checks++;
    if (a_cti !== 3'b000 || a_bte !== 2'b00 || b_cti !== 3'b000 || b_bte !== 2'b00 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_const: a_cti=%b a_bte=%b b_cti=%b b_bte=%b b_busy=%b, required 0", a_cti, a_bte, b_cti, b_bte, b_busy);
    end
  endtask

  task automatic test_basic();
    a_ifr = 8'h05;
    a_irq = 1'b1;
    checks++;
    if (a_busy !== 1'b0) begin errors++; $display("FAIL basic_c0_busy: got %b required 0", a_busy); end
    tick(); // cycle 1
    a_irq = 1'b0;
    checks++;
    if (a_cyc !== 1'b1 || a_stb !== 1'b1 || a_we !== 1'b0 || a_adr !== 32'h0000_000C) begin
      errors++;
      $display("FAIL basic_c1_read: cyc=%b stb=%b we=%b adr=%h, required 1 1 0 0000000c", a_cyc, a_stb, a_we, a_adr);
    end
    tick(); // cycle 2
    checks++;
    if (a_stb !== 1'b0 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_c2_rdlat: stb=%b busy=%b, required 0 1", a_stb, a_busy);
    end
    tick(); // cycle 3
    checks++;
    if (a_stb !== 1'b1 || a_we !== 1'b1 || a_adr !== 32'h0000_000C || a_dat_o !== 8'h00) begin
      errors++;
      $display("FAIL basic_c3_write: stb=%b we=%b adr=%h dat=%h, required 1 1 0000000c 00", a_stb, a_we, a_adr, a_dat_o);
    end
    tick(); // cycle 4
    checks++;
    if (a_valid !== 1'b0) begin errors++; $display("FAIL basic_c4_valid: got %b required 0", a_valid); end
    tick(); // cycle 5
    checks++;
    if (a_valid !== 1'b1 || a_data !== 8'h05 || a_level !== 3'd1) begin
      errors++;
      $display("FAIL basic_c5_event: valid=%b data=%h level=%0d, required 1 05 1", a_valid, a_data, a_level);
    end
    tick(); // cycle 6
    checks++;
    if (a_busy !== 1'b1) begin errors++; $display("FAIL basic_c6_hold: busy=%b required 1", a_busy); end
    tick(); // cycle 7
    checks++;
    if (a_busy !== 1'b0) begin errors++; $display("FAIL basic_c7_idle: busy=%b required 0", a_busy); end
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    checks++;
    if (a_level !== 3'd0 || a_valid !== 1'b0 || a_data !== 8'h00) begin
      errors++;
      $display("FAIL basic_pop: level=%0d valid=%b data=%h, required 0 0 00", a_level, a_valid, a_data);
    end
  endtask

  task automatic test_spurious();
    int wr0 = a_wr_cnt;
    a_ifr = 8'h00;
    a_irq = 1'b1;
    tick();
    a_irq = 1'b0;
    tick();
    tick(); // cycle 3
    checks++;
    if (a_busy !== 1'b0 || a_wr_cnt !== wr0 || a_level !== 3'd0) begin
      errors++;
      $display("FAIL spurious: busy=%b writes=%0d level=%0d, required 0 %0d 0", a_busy, a_wr_cnt, a_level, wr0);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_q [4] = '{8'h02, 8'h03, 8'h04, 8'h06};
    for (int v = 1; v <= 5; v++) run_event_a(8'(v), "ovf_fill");
    checks++;
    if (a_level !== 3'd4 || a_ovf !== 1'b1 || a_data !== 8'h01) begin
      errors++;
      $display("FAIL overflow_full: level=%0d ovf=%b head=%h, required 4 1 01", a_level, a_ovf, a_data);
    end
    pulse_sclr();
    checks++;
    if (a_ovf !== 1'b0) begin errors++; $display("FAIL overflow_clr: ovf=%b required 0", a_ovf); end
    a_ifr = 8'h06;
    a_irq = 1'b1;
    tick();
    a_irq = 1'b0;
    tick();
    tick();
    tick(); // cycle 4: PUSH, pop in same cycle
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    checks++;
    if (a_level !== 3'd4 || a_ovf !== 1'b0 || a_data !== 8'h02) begin
      errors++;
      $display("FAIL overflow_pushpop: level=%0d ovf=%b head=%h, required 4 0 02", a_level, a_ovf, a_data);
    end
    wait_idle_a("ovf_pushpop");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (a_data !== exp_q[i]) begin
        errors++;
        $display("FAIL overflow_drain[%0d]: data=%h required %h", i, a_data, exp_q[i]);
      end
      a_ready = 1'b1;
      tick();
      a_ready = 1'b0;
    end
    checks++;
    if (a_level !== 3'd0) begin errors++; $display("FAIL overflow_empty: level=%0d required 0", a_level); end
  endtask

  task automatic test_timeout();
    int n = 0;
    a_noack = 1'b1;
    a_irq   = 1'b1;
    tick();
    a_irq = 1'b0;
    while (a_stb && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 15) begin errors++; $display("FAIL timeout_len: stb cycles=%0d required 15", n); end
    checks++;
    if (a_fault !== 1'b1 || a_busy !== 1'b0 || a_cyc !== 1'b0) begin
      errors++;
      $display("FAIL timeout_state: fault=%b busy=%b cyc=%b, required 1 0 0", a_fault, a_busy, a_cyc);
    end
    a_noack = 1'b0;
    pulse_sclr();
    checks++;
    if (a_fault !== 1'b0) begin errors++; $display("FAIL timeout_clr: fault=%b required 0", a_fault); end
    a_err_wr = 1'b1;
    run_event_a(8'h33, "err_wr");
    a_err_wr = 1'b0;
    checks++;
    if (a_fault !== 1'b1 || a_level !== 3'd0 || a_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_wr: fault=%b level=%0d valid=%b, required 1 0 0", a_fault, a_level, a_valid);
    end
    pulse_sclr();
  endtask

  task automatic test_reset_mid();
    run_event_a(8'h11, "rst_pre");
    a_ifr = 8'h44;
    a_irq = 1'b1;
    tick();
    a_irq = 1'b0;
    tick();
    tick(); // cycle 3: WR
    checks++;
    if (a_cyc !== 1'b1 || a_we !== 1'b1 || a_level !== 3'd1) begin
      errors++;
      $display("FAIL rstmid_pre: cyc=%b we=%b level=%0d, required 1 1 1", a_cyc, a_we, a_level);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (a_cyc !== 1'b0 || a_stb !== 1'b0 || a_level !== 3'd0 || a_busy !== 1'b0 || a_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_post: cyc=%b stb=%b level=%0d busy=%b valid=%b, required all 0", a_cyc, a_stb, a_level, a_busy, a_valid);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_disable();
    int hits = 0;
    a_ifr = 8'h5A;
    a_irq = 1'b1;
    tick();
    a_irq = 1'b0;
    tick(); // RDLAT
    a_en = 1'b0;
    wait_idle_a("disable");
    checks++;
    if (a_level !== 3'd1 || a_data !== 8'h5A) begin
      errors++;
      $display("FAIL disable_complete: level=%0d data=%h, required 1 5a", a_level, a_data);
    end
    a_irq = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (a_busy) hits++;
    end
    a_irq = 1'b0;
    checks++;
    if (hits !== 0 || a_level !== 3'd1) begin
      errors++;
      $display("FAIL disable_block: busy cycles=%0d level=%0d, required 0 1", hits, a_level);
    end
    a_en    = 1'b1;
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
  endtask

  task automatic test_wait_state();
    int n = 0;
    b_ifr = 8'hA0;
    b_irq = 1'b1;
    tick();
    b_irq = 1'b0;
    while (b_busy && n < 80) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 80) begin errors++; $display("FAIL wait_idle_timeout: busy=%b after %0d cycles, required 0", b_busy, n); end
    checks++;
    if (b_valid !== 1'b1 || b_data !== 8'hA0 || b_level !== 3'd1 || b_fault !== 1'b0 || b_ovf !== 1'b0) begin
      errors++;
      $display("FAIL wait_capture: valid=%b data=%h level=%0d fault=%b ovf=%b, required 1 a0 1 0 0", b_valid, b_data, b_level, b_fault, b_ovf);
    end
    checks++;
    if (b_unstable !== 0 || b_adr_bad !== 0 || b_stb_cycles !== 8) begin
      errors++;
      $display("FAIL wait_stable: unstable=%0d bad_adr=%0d stb_cycles=%0d, required 0 0 8", b_unstable, b_adr_bad, b_stb_cycles);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_en = 1'b1; a_irq = 1'b0; a_ready = 1'b0; a_sclr = 1'b0;
    a_ifr = 8'h00; a_noack = 1'b0; a_err_wr = 1'b0;
    b_en = 1'b1; b_irq = 1'b0; b_ifr = 8'h00;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic();
    test_spurious();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_disable();
    test_wait_state();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
